// File: rtl/ex_mem_stage.sv
// EX stage and EX/MEM pipeline register for the 5-stage MIPS pipeline.
// Single-cycle ALU ops register in one edge; MULT runs a 32-step shift-add unit and stalls upstream.
module ex_mem_stage #(
   parameter int MULT_ITERS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [1:0]  wb_ctl,
   input  logic [2:0]  m_ctl,
   input  logic [3:0]  ex_ctl,
   input  logic [31:0] npc,
   input  logic [31:0] rdata1,
   input  logic [31:0] rdata2,
   input  logic [31:0] s_extended,
   input  logic [4:0]  instr_2016,
   input  logic [4:0]  instr_1511,
   output logic        stall_out,
   output logic [1:0]  wb_ctlout,
   output logic [2:0]  m_ctlout,
   output logic [31:0] add_result,
   output logic        zero,
   output logic [31:0] alu_result,
   output logic [31:0] rdata2out,
   output logic [4:0]  muxout
);

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MULT, ALU_ZERO
   } alu_op_t;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_state_t;

   localparam int              CNT_W     = $clog2(MULT_ITERS);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MULT_ITERS - 1);

   logic        reg_dst;
   logic [1:0]  alu_op_sel;
   logic        alu_src;
   logic [5:0]  funct;
   logic [31:0] op_b;
   logic [31:0] alu_res;
   alu_op_t     alu_op;
   logic        is_mult;

   mult_state_t      state_q, state_d;
   logic [CNT_W-1:0] count_q;
   logic [31:0]      mcand_q, mplier_q, acc_q;
   logic             launch;
   logic             bubble;

   assign reg_dst    = ex_ctl[3];
   assign alu_op_sel = ex_ctl[2:1];
   assign alu_src    = ex_ctl[0];
   assign funct      = s_extended[5:0];
   assign op_b       = alu_src ? s_extended : rdata2;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin : alu_decode
      alu_op = ALU_ADD;
      case (alu_op_sel)
         2'b01: alu_op = ALU_SUB;
         2'b10: begin
            case (funct)
               6'b100000: alu_op = ALU_ADD;
               6'b100010: alu_op = ALU_SUB;
               6'b100100: alu_op = ALU_AND;
               6'b100101: alu_op = ALU_OR;
               6'b101010: alu_op = ALU_SLT;
               6'b011000: alu_op = ALU_MULT;
               default:   alu_op = ALU_ZERO;
            endcase
         end
         default: alu_op = ALU_ADD;
      endcase
   end

   assign is_mult = (alu_op == ALU_MULT);

   // A MULT reads the accumulator; it only holds the full product in DONE, which is the cycle that registers it.
   always_comb begin : alu
      alu_res = '0;
      case (alu_op)
         ALU_ADD:  alu_res = rdata1 + op_b;
         ALU_SUB:  alu_res = rdata1 - op_b;
         ALU_AND:  alu_res = rdata1 & op_b;
         ALU_OR:   alu_res = rdata1 | op_b;
         ALU_SLT:  alu_res = {31'd0, $signed(rdata1) < $signed(op_b)};
         ALU_MULT: alu_res = acc_q;
         default:  alu_res = '0;
      endcase
   end

   always_comb begin : mult_next
      state_d = state_q;
      launch  = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_mult && !flush) begin
               state_d = BUSY;
               launch  = 1'b1;
            end
         end
         BUSY: begin
            if (flush)                    state_d = IDLE;
            else if (count_q == LAST_ITER) state_d = DONE;
         end
         DONE:    state_d = IDLE;   // no relaunch even if the MULT is still presented
         default: state_d = IDLE;
      endcase
   end

   assign stall_out = !rst && (launch || (state_q == BUSY));
   assign bubble    = flush || stall_out;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin : mult_regs
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         state_q <= state_d;
         if (launch) begin
            mcand_q  <= rdata1;
            mplier_q <= rdata2;
            acc_q    <= '0;
            count_q  <= '0;
         end else if (state_q == BUSY) begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin : ex_mem_regs
      if (rst) begin
         wb_ctlout  <= '0;
         m_ctlout   <= '0;
         add_result <= '0;
         zero       <= 1'b0;
         alu_result <= '0;
         rdata2out  <= '0;
         muxout     <= '0;
      end else begin
         wb_ctlout  <= bubble ? 2'b00  : wb_ctl;
         m_ctlout   <= bubble ? 3'b000 : m_ctl;
         add_result <= npc + (s_extended << 2);
         zero       <= (alu_res == '0);
         alu_result <= alu_res;
         rdata2out  <= rdata2;
         muxout     <= reg_dst ? instr_1511 : instr_2016;
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: vector table through a scoreboard queue,
// plus hand-written MULT, flush and reset sequences.
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic [1:0]  wb_ctl;
   logic [2:0]  m_ctl;
   logic [3:0]  ex_ctl;
   logic [31:0] npc, rdata1, rdata2, s_extended;
   logic [4:0]  instr_2016, instr_1511;
   logic        stall_out;
   logic [1:0]  wb_ctlout;
   logic [2:0]  m_ctlout;
   logic [31:0] add_result, alu_result, rdata2out;
   logic        zero;
   logic [4:0]  muxout;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        flush;
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [3:0]  ex;
      logic [31:0] npc, r1, r2, sx;
      logic [4:0]  rt, rd;
      logic [31:0] e_alu;
      logic        e_zero;
      logic [31:0] e_add;
      logic [4:0]  e_mux;
   } vec_t;

   typedef struct {
      logic        ctl_only;
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [31:0] add, alu, rd2;
      logic        zero;
      logic [4:0]  mux;
   } exp_t;

   vec_t vecs [0:11];
   exp_t sb[$];

   ex_mem_stage #(.MULT_ITERS(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .wb_ctl(wb_ctl), .m_ctl(m_ctl), .ex_ctl(ex_ctl),
      .npc(npc), .rdata1(rdata1), .rdata2(rdata2), .s_extended(s_extended),
      .instr_2016(instr_2016), .instr_1511(instr_1511), .stall_out(stall_out),
      .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .add_result(add_result), .zero(zero),
      .alu_result(alu_result), .rdata2out(rdata2out), .muxout(muxout)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".stall"}, 32'(stall_out), 32'd0);
      check({tag, ".wb"},    32'(wb_ctlout), 32'd0);
      check({tag, ".m"},     32'(m_ctlout),  32'd0);
      check({tag, ".add"},   add_result,     32'd0);
      check({tag, ".zero"},  32'(zero),      32'd0);
      check({tag, ".alu"},   alu_result,     32'd0);
      check({tag, ".rd2"},   rdata2out,      32'd0);
      check({tag, ".mux"},   32'(muxout),    32'd0);
   endtask

   task automatic pop_compare(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      check({tag, ".wb"}, 32'(wb_ctlout), 32'(e.wb));
      check({tag, ".m"},  32'(m_ctlout),  32'(e.m));
      if (!e.ctl_only) begin
         check({tag, ".add"},  add_result,  e.add);
         check({tag, ".alu"},  alu_result,  e.alu);
         check({tag, ".zero"}, 32'(zero),   32'(e.zero));
         check({tag, ".rd2"},  rdata2out,   e.rd2);
         check({tag, ".mux"},  32'(muxout), 32'(e.mux));
      end
   endtask

   task automatic drive_vec(input vec_t v);
      exp_t e;
      flush = v.flush; wb_ctl = v.wb; m_ctl = v.m; ex_ctl = v.ex; npc = v.npc;
      rdata1 = v.r1; rdata2 = v.r2; s_extended = v.sx; instr_2016 = v.rt; instr_1511 = v.rd;
      e.ctl_only = v.flush;
      e.wb   = v.flush ? 2'b00 : v.wb;
      e.m    = v.flush ? 3'b000 : v.m;
      e.add  = v.e_add;
      e.alu  = v.e_alu;
      e.zero = v.e_zero;
      e.rd2  = v.r2;
      e.mux  = v.e_mux;
      sb.push_back(e);
   endtask

   // Presents an R-type MULT (rd=10, npc=0x300) and follows it through the stall to its result.
   task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] prod);
      vec_t v;
      int   stall_cnt = 0;
      int   bad_bubbles = 0;
      v = '{1'b0, 2'b10, 3'b000, 4'b1100, 32'h300, a, b, 32'h18, 5'd1, 5'd10,
            prod, (prod == 32'd0), 32'h360, 5'd10};
      @(negedge clk);
      drive_vec(v);
      #1;
      while (stall_out === 1'b1 && stall_cnt < 100) begin
         stall_cnt++;
         @(posedge clk); #1;
         if (wb_ctlout !== 2'b00 || m_ctlout !== 3'b000) bad_bubbles++;
         @(negedge clk); #1;
      end
      check({tag, ".stall_cycles"}, 32'(stall_cnt), 32'd33);
      check({tag, ".bubbles"}, 32'(bad_bubbles), 32'd0);
      @(posedge clk); #1;
      pop_compare(tag);
      // The MULT was still presented during DONE; a relaunch would show as a stall now.
      @(negedge clk);
      v = '{1'b0, 2'b10, 3'b000, 4'b1100, 32'h0, 32'd1, 32'd1, 32'h20, 5'd1, 5'd3,
            32'd2, 1'b0, 32'h80, 5'd3};
      drive_vec(v);
      #1;
      check({tag, ".no_relaunch"}, 32'(stall_out), 32'd0);
      @(posedge clk); #1;
      pop_compare({tag, ".after"});
   endtask

   initial begin
      vec_t v;
      exp_t e;
      vecs[0]  = '{1'b0, 2'b10, 3'b000, 4'b1100, 32'h100, 32'd5, 32'd5, 32'h22, 5'd3, 5'd9,
                   32'd0, 1'b1, 32'h188, 5'd9};
      vecs[1]  = '{1'b0, 2'b11, 3'b010, 4'b0001, 32'h40, 32'h100, 32'hDEAD, 32'hFFFFFFFC, 5'd7, 5'd2,
                   32'hFC, 1'b0, 32'h30, 5'd7};
      vecs[2]  = '{1'b0, 2'b10, 3'b000, 4'b1100, 32'h200, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd1, 5'd4,
                   32'd1, 1'b0, 32'h2A8, 5'd4};
      vecs[3]  = '{1'b0, 2'b10, 3'b000, 4'b1100, 32'h200, 32'd1, 32'hFFFFFFFF, 32'h2A, 5'd1, 5'd4,
                   32'd0, 1'b1, 32'h2A8, 5'd4};
      vecs[4]  = '{1'b0, 2'b10, 3'b000, 4'b1100, 32'h0, 32'h7FFFFFFF, 32'd1, 32'h20, 5'd2, 5'd5,
                   32'h80000000, 1'b0, 32'h80, 5'd5};
      vecs[5]  = '{1'b0, 2'b10, 3'b000, 4'b1100, 32'h4, 32'hF0F0, 32'hFF00, 32'h24, 5'd2, 5'd6,
                   32'hF000, 1'b0, 32'h94, 5'd6};
      vecs[6]  = '{1'b0, 2'b10, 3'b000, 4'b1100, 32'h4, 32'hF0F0, 32'h0F0F, 32'h25, 5'd2, 5'd7,
                   32'hFFFF, 1'b0, 32'h98, 5'd7};
      vecs[7]  = '{1'b0, 2'b10, 3'b000, 4'b1100, 32'h0, 32'd1, 32'd2, 32'h27, 5'd2, 5'd8,
                   32'd0, 1'b1, 32'h9C, 5'd8};
      vecs[8]  = '{1'b0, 2'b00, 3'b100, 4'b0010, 32'h1000, 32'd10, 32'd10, 32'h10, 5'd11, 5'd12,
                   32'd0, 1'b1, 32'h1040, 5'd11};
      vecs[9]  = '{1'b0, 2'b00, 3'b001, 4'b0111, 32'h8, 32'hFFFFFFFF, 32'h55, 32'd1, 5'd13, 5'd14,
                   32'd0, 1'b1, 32'hC, 5'd13};
      vecs[10] = '{1'b0, 2'b10, 3'b000, 4'b1100, 32'h0, 32'd0, 32'd1, 32'h22, 5'd2, 5'd15,
                   32'hFFFFFFFF, 1'b0, 32'h88, 5'd15};
      vecs[11] = '{1'b1, 2'b11, 3'b010, 4'b0001, 32'h0, 32'd1, 32'd1, 32'd1, 5'd1, 5'd2,
                   32'd2, 1'b0, 32'h4, 5'd1};

      // Reset with random inputs for two edges.
      rst = 1'b1;
      flush = 1'($urandom); wb_ctl = 2'($urandom); m_ctl = 3'($urandom); ex_ctl = 4'($urandom);
      npc = $urandom; rdata1 = $urandom; rdata2 = $urandom; s_extended = $urandom;
      instr_2016 = 5'($urandom); instr_1511 = 5'($urandom);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check_all_zero($sformatf("reset%0d", i));
      end

      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (i != 0) @(negedge clk);
         drive_vec(vecs[i]);
         #1;
         check($sformatf("vec%0d.stall", i), 32'(stall_out), 32'd0);
         @(posedge clk); #1;
         pop_compare($sformatf("vec%0d", i));
      end

      // Flush in the same cycle a MULT is presented: no launch, bubble captured.
      @(negedge clk);
      v = '{1'b1, 2'b10, 3'b000, 4'b1100, 32'h0, 32'd7, 32'd6, 32'h18, 5'd1, 5'd10,
            32'd0, 1'b0, 32'h60, 5'd10};
      drive_vec(v);
      #1;
      check("flush_mult_idle.stall", 32'(stall_out), 32'd0);
      @(posedge clk); #1;
      pop_compare("flush_mult_idle");

      do_mult("mult7x6", 32'd7, 32'd6, 32'd42);
      do_mult("multFFx2", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);

      // Flush at BUSY iteration 10, then an add of 3+4 on the following cycle.
      @(negedge clk);
      v = '{1'b0, 2'b10, 3'b000, 4'b1100, 32'h0, 32'd5, 32'd5, 32'h18, 5'd1, 5'd10,
            32'd0, 1'b0, 32'h60, 5'd10};
      drive_vec(v);
      void'(sb.pop_back());
      @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      check("flush_busy.wb", 32'(wb_ctlout), 32'd0);
      check("flush_busy.m",  32'(m_ctlout),  32'd0);
      @(negedge clk);
      v = '{1'b0, 2'b10, 3'b010, 4'b0000, 32'h20, 32'd3, 32'd4, 32'h1, 5'd6, 5'd9,
            32'd7, 1'b0, 32'h24, 5'd6};
      drive_vec(v);
      #1;
      check("flush_busy.stall_next", 32'(stall_out), 32'd0);
      @(posedge clk); #1;
      pop_compare("add_after_flush");

      // Reset at BUSY iteration 20, then a clean MULT 3x3.
      @(negedge clk);
      v = '{1'b0, 2'b10, 3'b000, 4'b1100, 32'h0, 32'd9, 32'd9, 32'h18, 5'd1, 5'd10,
            32'd0, 1'b0, 32'h60, 5'd10};
      drive_vec(v);
      void'(sb.pop_back());
      @(posedge clk);
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check_all_zero("reset_busy");
      @(negedge clk);
      rst = 1'b0;
      v = '{1'b0, 2'b10, 3'b000, 4'b1100, 32'h0, 32'd1, 32'd1, 32'h20, 5'd1, 5'd3,
            32'd2, 1'b0, 32'h80, 5'd3};
      drive_vec(v);
      #1;
      check("reset_busy.stall_next", 32'(stall_out), 32'd0);
      @(posedge clk); #1;
      pop_compare("reset_busy.after");

      do_mult("mult3x3", 32'd3, 32'd3, 32'd9);

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      e = '{1'b0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0};
      if (e.ctl_only) $display("unused");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
